mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one 8x8 signed sequential multiplier among N_REQ requesters.
- Multiplier interface: start pulse, ready level, 8 multiply steps.
- Arbitrates round-robin, registers operands, issues a start pulse and waits for ready.
- Returns the 16-bit product on a shared result bus tagged with the requester ID.
- Sits between client datapath blocks and the single multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- ID_W, 2, result tag width; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  request level per requester; held until gnt.
- a_in  in  N_REQ*W  operand A per requester; slice i = bits [i*W +: W].
- b_in  in  N_REQ*W  operand B per requester, same slicing.
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted.
- res_valid  out  1  one-cycle pulse: result on res_product/res_id.
- res_id  out  ID_W  index of the requester owning the result.
- res_product  out  2*W  signed product.
- res_err  out  1  result invalid (timeout); see Optional Feature.
- mul_start  out  1  start pulse to the multiplier.
- mul_a  out  W  multiplicand to the multiplier.
- mul_b  out  W  multiplier operand to the multiplier.
- mul_product  in  2*W  multiplier product.
- mul_ready  in  1  multiplier done level.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0; gnt, res_valid, res_err, mul_start = 0; res_id, res_product, mul_a, mul_b = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from ptr, wrapping at N_REQ.
  - At that edge: mul_a/mul_b <= winner's a_in/b_in slices; cur_id <= winner; gnt <= onehot(winner); mul_start <= 1; state -> ISSUE.
  - If no req bit is set, remain in IDLE.
- ISSUE (exactly 1 cycle): the multiplier loads at the end of this cycle. gnt <= 0, mul_start <= 0, state -> WAIT.
- WAIT: mul_ready is sampled only in this state.
  - On mul_ready=1: res_product <= mul_product, res_id <= cur_id, res_valid <= 1, ptr <= (cur_id+1) mod N_REQ, state -> IDLE.
- mul_ready is ignored in IDLE and ISSUE. It stays high from the previous operation until the multiplier sees start, so this is mandatory.
- Latency: req seen in IDLE at cycle 0 -> gnt and mul_start high in cycle 1 -> res_valid in cycle 11 (8 multiply steps plus 3 cycles).
- Throughput: one operation per 11 cycles.
- A new grant can issue at the edge ending the res_valid cycle, since the FSM is already in IDLE.
- Requesters:
  - Must hold req and operands stable until they see gnt.
  - req still high in the cycle after gnt counts as a new request.
  - req deasserted before grant withdraws the request.
- Simultaneous requests: the round-robin pointer guarantees each active requester is served within N_REQ operations.
- Operand changes after grant have no effect on the operation in flight.
- Reset mid-operation: state returns to IDLE immediately and the result is discarded. The multiplier has no reset; the next operation still goes through ISSUE before ready is sampled.
- Arithmetic: no arithmetic in this block; res_product is mul_product unmodified.

Optional Feature:
- Macro: MULT_SHARE_ARBITER_TIMEOUT_EN.
- When defined:
  - A 4-bit watchdog clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches 15 without mul_ready: res_valid <= 1, res_err <= 1, res_product <= 0, res_id <= cur_id, ptr advances, state -> IDLE.
  - res_err is otherwise 0, and always 0 alongside a normal result.
- When undefined: no watchdog; WAIT holds indefinitely; res_err is tied to 0.

Decomposition:
- Package mult_share_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - default N_REQ, W and ID_W constants;
  - TIMEOUT_CYCLES=15.
- One sub-module: rr_pick, a combinational round-robin pick. Inputs req and ptr; outputs found, winner index and one-hot grant.

Test Plan:
- Single request: req[2]=1, a=4, b=-3 (8'hFD) -> gnt=4'b0100 in cycle 1; res_valid in cycle 11 with res_id=2, res_product=16'hFFF4.
- All four requesting from reset: grants in order 0,1,2,3. Requester 0 re-requesting immediately is next served after 3, not before 1.
- Back-to-back with held req: two operations 3*5 then 7*7 -> second res_product=16'h0031, not a stale 16'h000F. Confirms ready is ignored during ISSUE.
- Extremes: a=-128, b=-128 -> 16'h4000. a=127, b=-128 -> 16'hC080.
- Reset pulse mid-WAIT (cycle 5) -> no res_valid. All outputs 0 immediately. A following request completes correctly with latency 11.
- Macro defined, multiplier model holds mul_ready=0 -> res_valid with res_err=1 and res_product=0, 15 cycles after WAIT entry. FSM then returns to IDLE and serves the next requester.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// The optional watchdog is enabled by MULT_SHARE_ARBITER_TIMEOUT_EN.
package mult_share_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int N_REQ_DEF      = 4;
   localparam int W_DEF          = 8;
   localparam int ID_W_DEF       = 2;
   localparam int TIMEOUT_CYCLES = 15;
   localparam int WDOG_W         = 4;

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  winner,
   output logic [N_REQ-1:0] grant
);

   always_comb begin
      int idx;
      logic [ID_W-1:0] idx_l;
      found  = 1'b0;
      winner = '0;
      grant  = '0;
      idx    = 0;
      idx_l  = '0;
      // Walk farthest-first so the candidate closest to ptr overwrites last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_l = ID_W'(idx);
         if (req[idx_l]) begin
            found        = 1'b1;
            winner       = idx_l;
            grant        = '0;
            grant[idx_l] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one sequential signed multiplier among N_REQ clients.
// Define MULT_SHARE_ARBITER_TIMEOUT_EN to add a WAIT-state watchdog that flags res_err.
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] a_in,
   input  logic [N_REQ*W-1:0] b_in,
   output logic [N_REQ-1:0]   gnt,
   output logic               res_valid,
   output logic [ID_W-1:0]    res_id,
   output logic [2*W-1:0]     res_product,
   output logic               res_err,
   output logic               mul_start,
   output logic [W-1:0]       mul_a,
   output logic [W-1:0]       mul_b,
   input  logic [2*W-1:0]     mul_product,
   input  logic               mul_ready
);

   state_t                  state, state_d;
   logic [ID_W-1:0]         ptr, ptr_d, cur_id, cur_id_d, nxt_ptr;
   logic [N_REQ-1:0]        gnt_d;
   logic                    mul_start_d, res_valid_d;
   logic [W-1:0]            mul_a_d, mul_b_d;
   logic [ID_W-1:0]         res_id_d;
   logic [2*W-1:0]          res_product_d;
   logic [N_REQ-1:0][W-1:0] a_vec, b_vec;
   logic                    pick_found;
   logic [ID_W-1:0]         pick_id;
   logic [N_REQ-1:0]        pick_gnt;

   assign a_vec = a_in;
   assign b_vec = b_in;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .found  (pick_found),
      .winner (pick_id),
      .grant  (pick_gnt)
   );

   assign nxt_ptr = (cur_id == ID_W'(N_REQ - 1)) ? '0 : ID_W'(cur_id + 1'b1);

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
   logic [WDOG_W-1:0] wdog, wdog_d;
   logic              res_err_q, res_err_d;
   assign res_err = res_err_q;
`else
   assign res_err = 1'b0;
`endif

   always_comb begin
      state_d       = state;
      ptr_d         = ptr;
      cur_id_d      = cur_id;
      gnt_d         = '0;
      mul_start_d   = 1'b0;
      mul_a_d       = mul_a;
      mul_b_d       = mul_b;
      res_valid_d   = 1'b0;
      res_id_d      = res_id;
      res_product_d = res_product;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
      wdog_d        = wdog;
      res_err_d     = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               mul_a_d     = a_vec[pick_id];
               mul_b_d     = b_vec[pick_id];
               cur_id_d    = pick_id;
               gnt_d       = pick_gnt;
               mul_start_d = 1'b1;
               state_d     = ISSUE;
            end
         end
         // mul_ready may still be high from the last operation here; never sample it.
         ISSUE: begin
            state_d = WAIT;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
            wdog_d  = '0;
`endif
         end
         WAIT: begin
            if (mul_ready) begin
               res_valid_d   = 1'b1;
               res_id_d      = cur_id;
               res_product_d = mul_product;
               ptr_d         = nxt_ptr;
               state_d       = IDLE;
            end
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
            else if (wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
               res_valid_d   = 1'b1;
               res_err_d     = 1'b1;
               res_id_d      = cur_id;
               res_product_d = '0;
               ptr_d         = nxt_ptr;
               state_d       = IDLE;
            end else begin
               wdog_d = wdog + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         cur_id      <= '0;
         gnt         <= '0;
         mul_start   <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
         res_valid   <= 1'b0;
         res_id      <= '0;
         res_product <= '0;
      end else begin
         state       <= state_d;
         ptr         <= ptr_d;
         cur_id      <= cur_id_d;
         gnt         <= gnt_d;
         mul_start   <= mul_start_d;
         mul_a       <= mul_a_d;
         mul_b       <= mul_b_d;
         res_valid   <= res_valid_d;
         res_id      <= res_id_d;
         res_product <= res_product_d;
      end
   end

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog      <= '0;
         res_err_q <= 1'b0;
      end else begin
         wdog      <= wdog_d;
         res_err_q <= res_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed vector table, corner sequences, and a
// randomized run scored against a queue-based round-robin reference.
module tb_mult_share_arbiter;
   localparam int N = 4, W = 8, IDW = 2;

   logic           clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] a_in = '0, b_in = '0;
   logic [N-1:0]   gnt;
   logic           res_valid, res_err, mul_start, mul_ready;
   logic [IDW-1:0] res_id;
   logic [2*W-1:0] res_product, mul_product;
   logic [W-1:0]   mul_a, mul_b;

   int total = 0, bad = 0, cyc = 0;
   bit mon_en = 1'b0;

   mult_share_arbiter #(.N_REQ(N), .W(W), .ID_W(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .res_valid(res_valid), .res_id(res_id), .res_product(res_product),
      .res_err(res_err), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_product(mul_product), .mul_ready(mul_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sequential multiplier model: no reset, ready stays high until it sees start.
   logic [15:0] m_prod = '0, m_acc = '0;
   logic        m_ready = 1'b1;
   int          m_cnt = 0;
   bit          stuck = 1'b0;
   always @(posedge clk) begin
      if (mul_start) begin
         m_ready <= 1'b0;
         m_cnt   <= 8;
         m_acc   <= $signed(mul_a) * $signed(mul_b);
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1 && !stuck) begin
            m_ready <= 1'b1;
            m_prod  <= m_acc;
         end
      end
   end
   assign mul_ready   = m_ready;
   assign mul_product = m_prod;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Single request from an idle arbiter: grant in cycle 1, result in cycle 11.
   task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod, input string nm);
      int c0, n;
      a_in[id*W +: W] = a;
      b_in[id*W +: W] = b;
      req[id] = 1'b1;
      c0 = cyc;
      step();
      chk({nm, ".gnt"}, 32'(gnt), 32'(1 << id));
      chk({nm, ".start"}, 32'(mul_start), 32'd1);
      req[id] = 1'b0;
      n = 0;
      while (!res_valid && n < 40) begin step(); n++; end
      chk({nm, ".lat"}, 32'(cyc - c0), 32'd11);
      chk({nm, ".id"}, 32'(res_id), 32'(id));
      chk({nm, ".prod"}, 32'(res_product), 32'(prod));
      chk({nm, ".err"}, 32'(res_err), 32'd0);
      step();
      chk({nm, ".pulse"}, 32'(res_valid), 32'd0);
   endtask

   // Reference model for the random phase: rotate from the last served id,
   // expect the signed product ten cycles after each grant.
   typedef struct { int id; logic [15:0] prod; int due; } exp_t;
   exp_t           expq[$];
   logic [N-1:0]   p_req = '0;
   logic [N*W-1:0] p_a = '0, p_b = '0;
   int             last = N - 1;
   bit             busy = 1'b0;

   always @(negedge clk) begin
      int w, ix;
      logic [15:0] pr;
      exp_t e;
      w = -1;
      if (!rst_n) begin
         last = N - 1;
         busy = 1'b0;
         expq.delete();
      end else if (mon_en) begin
         if (!busy)
            for (int k = 1; k <= N; k++) begin
               ix = (last + k) % N;
               if (w < 0 && p_req[ix]) w = ix;
            end
         chk("rnd.gnt", 32'(gnt), (w < 0) ? 32'd0 : 32'(1 << w));
         if (w >= 0) begin
            pr = $signed(p_a[w*W +: W]) * $signed(p_b[w*W +: W]);
            expq.push_back('{w, pr, cyc + 10});
            last = w;
            busy = 1'b1;
         end
         if (res_valid) begin
            if (expq.size() == 0) chk("rnd.spurious", 32'd1, 32'd0);
            else begin
               e = expq.pop_front();
               chk("rnd.id", 32'(res_id), 32'(e.id));
               chk("rnd.prod", 32'(res_product), 32'(e.prod));
               chk("rnd.lat", 32'(cyc), 32'(e.due));
               chk("rnd.err", 32'(res_err), 32'd0);
            end
            busy = 1'b0;
         end else if (expq.size() > 0 && cyc > expq[0].due) begin
            chk("rnd.late", 32'(cyc), 32'(expq[0].due));
            void'(expq.pop_front());
            busy = 1'b0;
         end
      end
      p_req = req;
      p_a   = a_in;
      p_b   = b_in;
   end

   typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [15:0] prod; } vec_t;
   vec_t vt[7];

   initial begin
      int n, got, ng, g2;
      int order[$];
      logic [15:0] prods[2];
      int rcyc[2];

      vt[0] = '{2, 8'h04, 8'hFD, 16'hFFF4};
      vt[1] = '{0, 8'h80, 8'h80, 16'h4000};
      vt[2] = '{1, 8'h7F, 8'h80, 16'hC080};
      vt[3] = '{3, 8'h03, 8'h05, 16'h000F};
      vt[4] = '{3, 8'h07, 8'h07, 16'h0031};
      vt[5] = '{0, 8'hFF, 8'hFF, 16'h0001};
      vt[6] = '{1, 8'h00, 8'hB3, 16'h0000};

      // reset state
      step();
      chk("rst.gnt", 32'(gnt), 32'd0);
      chk("rst.valid", 32'(res_valid), 32'd0);
      chk("rst.start", 32'(mul_start), 32'd0);
      chk("rst.err", 32'(res_err), 32'd0);
      chk("rst.data", 32'({res_id, res_product, mul_a, mul_b}), 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].prod, $sformatf("vec%0d", i));

      // all four from reset; requester 0 keeps requesting
      do_reset();
      for (int i = 0; i < N; i++) begin
         a_in[i*W +: W] = 8'(i + 1);
         b_in[i*W +: W] = 8'd2;
      end
      req = '1;
      n = 0;
      while (order.size() < 5 && n < 200) begin
         step();
         n++;
         for (int i = 0; i < N; i++)
            if (gnt[i]) begin
               order.push_back(i);
               if (i != 0) req[i] = 1'b0;
            end
      end
      chk("rr.count", 32'(order.size()), 32'd5);
      for (int i = 0; i < order.size(); i++) chk($sformatf("rr.order%0d", i), 32'(order[i]), 32'(i % N));
      req = '0;
      n = 0;
      while (!res_valid && n < 40) begin step(); n++; end
      step();

      // back-to-back with held req: stale product must not be captured
      a_in[3*W +: W] = 8'd3; b_in[3*W +: W] = 8'd5; req[3] = 1'b1;
      n = 0; got = 0; ng = 0; g2 = 0;
      while (got < 2 && n < 60) begin
         step();
         n++;
         if (gnt[3]) begin
            if (ng == 0) begin a_in[3*W +: W] = 8'd7; b_in[3*W +: W] = 8'd7; end
            else begin req[3] = 1'b0; g2 = cyc; end
            ng++;
         end
         if (res_valid) begin prods[got] = res_product; rcyc[got] = cyc; got++; end
      end
      chk("b2b.count", 32'(got), 32'd2);
      chk("b2b.first", 32'(prods[0]), 32'h000F);
      chk("b2b.second", 32'(prods[1]), 32'h0031);
      chk("b2b.regrant", 32'(g2 - rcyc[0]), 32'd1);
      step();

      // reset pulse in the middle of WAIT
      begin
         int c0, nv;
         a_in[1*W +: W] = 8'd9; b_in[1*W +: W] = 8'd9; req[1] = 1'b1;
         c0 = cyc;
         step();
         req[1] = 1'b0;
         while (cyc < c0 + 5) step();
         #2 rst_n = 1'b0;
         #1;
         chk("midrst.ctl", 32'({gnt, res_valid, mul_start, res_err}), 32'd0);
         chk("midrst.data", 32'({res_id, res_product, mul_a, mul_b}), 32'd0);
         step();
         rst_n = 1'b1;
         nv = 0;
         repeat (15) begin step(); if (res_valid) nv++; end
         chk("midrst.novalid", 32'(nv), 32'd0);
         run_op(2, 8'hF6, 8'h0C, 16'hFF88, "postrst");
      end

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
      begin
         int c0;
         stuck = 1'b1;
         a_in[1*W +: W] = 8'd5; b_in[1*W +: W] = 8'd5; req[1] = 1'b1;
         c0 = cyc;
         step();
         chk("to.gnt", 32'(gnt), 32'b0010);
         req[1] = 1'b0;
         a_in[2*W +: W] = 8'd6; b_in[2*W +: W] = 8'd6; req[2] = 1'b1;
         n = 0;
         while (!res_valid && n < 40) begin step(); n++; end
         chk("to.lat", 32'(cyc - c0), 32'd17);
         chk("to.err", 32'(res_err), 32'd1);
         chk("to.prod", 32'(res_product), 32'd0);
         chk("to.id", 32'(res_id), 32'd1);
         stuck = 1'b0;
         step();
         chk("to.next", 32'(gnt), 32'b0100);
         req[2] = 1'b0;
         c0 = cyc;
         n = 0;
         while (!res_valid && n < 40) begin step(); n++; end
         chk("to.next.lat", 32'(cyc - c0), 32'd10);
         chk("to.next.prod", 32'(res_product), 32'h0024);
         chk("to.next.err", 32'(res_err), 32'd0);
         step();
      end
`endif

      // randomized traffic
      do_reset();
      mon_en = 1'b1;
      for (int t = 0; t < 2000; t++) begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if (gnt[i]) begin
                  if ($urandom_range(0, 1) == 1) begin
                     a_in[i*W +: W] = 8'($urandom);
                     b_in[i*W +: W] = 8'($urandom);
                  end else req[i] = 1'b0;
               end else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               a_in[i*W +: W] = 8'($urandom);
               b_in[i*W +: W] = 8'($urandom);
               req[i] = 1'b1;
            end
         end
         step();
      end
      req = '0;
      step();
      step();
      n = 0;
      while (busy && n < 60) begin step(); n++; end
      chk("rnd.drain", 32'(expq.size()), 32'd0);
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
